// File: rtl/reciprocal_arbiter.sv
// Round-robin arbiter sharing one combinational Q6.10 reciprocal datapath
// between NREQ requesters, with a shared tagged response channel.
module reciprocal_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [16*NREQ-1:0]   i_req_data,
  input  logic [NREQ-1:0]      i_req_abs,
  output logic                 o_resp_valid,
  input  logic                 i_resp_ready,
  output logic [15:0]          o_resp_data,
  output logic                 o_resp_sat,
  output logic [IDW-1:0]       o_resp_id,
  output logic                 o_busy,
  output logic [7:0]           o_sat_count,
  output logic [15:0]          o_rcp_i_data,
  output logic                 o_rcp_i_abs,
  input  logic [15:0]          i_rcp_o_data,
  input  logic                 i_rcp_o_sat
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = IDW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDW-1:0]    r_ptr;
  logic [DW-1:0]     r_op;
  logic              r_abs;
  logic [IDW-1:0]    r_id;
  logic              r_resp_valid;
  logic [DW-1:0]     r_resp_data;
  logic              r_resp_sat;
  logic [IDW-1:0]    r_resp_id;
  logic              r_busy;
  logic [CW-1:0]     r_sat_count;

  logic [2*NREQ-1:0] w_req_rot;
  logic              w_any;
  logic [IDW-1:0]    w_off;
  logic [SW-1:0]     w_sum;
  logic [IDW-1:0]    w_gnt;
  logic [IDW-1:0]    w_ptr_nxt;
  logic [DW-1:0]     w_op;
  logic              w_abs;
  logic              w_take;

  // Rotate requests so the pointer sits at bit 0; lowest set bit wins.
  always_comb begin
    w_req_rot = {i_req_valid, i_req_valid} >> r_ptr;
    w_any     = |i_req_valid;
    w_off     = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (w_req_rot[k]) w_off = IDW'(k);
    end
    w_sum = SW'(r_ptr) + SW'(w_off);
    if (w_sum >= SW'(NREQ)) w_sum = w_sum - SW'(NREQ);
    w_gnt = w_sum[IDW-1:0];
    if (w_gnt == IDW'(NREQ - 1)) w_ptr_nxt = '0;
    else                         w_ptr_nxt = w_gnt + IDW'(1);
  end

  always_comb begin
    w_op  = '0;
    w_abs = 1'b0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (w_gnt == IDW'(j)) begin
        w_op  = i_req_data[j*DW +: DW];
        w_abs = i_req_abs[j];
      end
    end
  end

  assign w_take = (r_state == S_IDLE) && w_any && rst_n;

  always_comb begin
    o_req_ready = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      o_req_ready[j] = w_take && (w_gnt == IDW'(j));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any)        w_state_nxt = S_CALC;
      S_CALC:                    w_state_nxt = S_RESP;
      S_RESP:  if (i_resp_ready) w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Operand capture, result capture and saturation bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_op         <= '0;
      r_abs        <= 1'b0;
      r_id         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_sat   <= 1'b0;
      r_resp_id    <= '0;
      r_sat_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_op  <= w_op;
            r_abs <= w_abs;
            r_id  <= w_gnt;
            r_ptr <= w_ptr_nxt;
          end
        end
        S_CALC: begin
          r_resp_data  <= i_rcp_o_data;
          r_resp_sat   <= i_rcp_o_sat;
          r_resp_id    <= r_id;
          r_resp_valid <= 1'b1;
        end
        S_RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            if (r_resp_sat && (r_sat_count != {CW{1'b1}})) begin
              r_sat_count <= r_sat_count + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_sat   = r_resp_sat;
  assign o_resp_id    = r_resp_id;
  assign o_busy       = r_busy;
  assign o_sat_count  = r_sat_count;
  assign o_rcp_i_data = r_op;
  assign o_rcp_i_abs  = r_abs;

endmodule
